// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
// Holds the FSM state enum, scan codes and the BCD time increment.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] d4;
      logic [3:0] d3;
      logic [3:0] d2;
      logic [3:0] d1;
   } bcd_time_t;

   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_R     = 8'h2D;
   localparam logic [7:0] KEY_L     = 8'h4B;
   localparam logic [7:0] BRK       = 8'hF0;
   localparam logic [7:0] EXT       = 8'hE0;

   localparam int FRAME_LEN = 11;

   // One-second ripple increment; 59:59 wraps to 00:00.
   function automatic bcd_time_t bcd_inc(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.d1 == 4'd9) begin
         r.d1 = 4'd0;
         if (t.d2 == 4'd5) begin
            r.d2 = 4'd0;
            if (t.d3 == 4'd9) begin
               r.d3 = 4'd0;
               r.d4 = (t.d4 == 4'd5) ? 4'd0 : t.d4 + 4'd1;
            end else begin
               r.d3 = t.d3 + 4'd1;
            end
         end else begin
            r.d2 = t.d2 + 4'd1;
         end
      end else begin
         r.d1 = t.d1 + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_ps2_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge sampling,
// start/odd-parity/stop checking and a mid-frame idle timeout.
module ps2_rx
   import stopwatch_pkg::*;
#(
   parameter int RX_TIMEOUT = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kb_clk,
   input  logic       kb_data,
   output logic [7:0] code,
   output logic       code_valid
);

   localparam int TW = $clog2(RX_TIMEOUT);

   logic          kbc_m, kbc_s, kbc_p;
   logic          kbd_m, kbd_s;
   logic          fall;
   logic [3:0]    bit_cnt;
   logic [9:0]    sh;
   logic [TW-1:0] to_cnt;
   logic          frame_ok;

   // Falling kbClk edge and full-frame validity from the held bits.
   always_comb begin
      fall     = kbc_p & ~kbc_s;
      frame_ok = ~sh[0] & (^sh[9:1]) & kbd_s;
   end

   // Synchronize, shift bits in on falling edges, emit good codes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kbc_m      <= 1'b1;
         kbc_s      <= 1'b1;
         kbc_p      <= 1'b1;
         kbd_m      <= 1'b1;
         kbd_s      <= 1'b1;
         bit_cnt    <= '0;
         sh         <= '0;
         to_cnt     <= '0;
         code       <= '0;
         code_valid <= 1'b0;
      end else begin
         kbc_m      <= kb_clk;
         kbc_s      <= kbc_m;
         kbc_p      <= kbc_s;
         kbd_m      <= kb_data;
         kbd_s      <= kbd_m;
         code_valid <= 1'b0;
         if (fall) begin
            to_cnt <= '0;
            sh     <= {kbd_s, sh[9:1]};
            if (bit_cnt == 4'd0) begin
               if (!kbd_s)
                  bit_cnt <= 4'd1;
            end else if (bit_cnt == 4'(FRAME_LEN - 1)) begin
               bit_cnt <= 4'd0;
               if (frame_ok) begin
                  code_valid <= 1'b1;
                  code       <= sh[8:1];
               end
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != 4'd0) begin
            if (to_cnt == TW'(RX_TIMEOUT - 1)) begin
               bit_cnt <= 4'd0;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: scan-code decode, IDLE/RUN/PAUSE FSM, prescaler, BCD time.
// Define STOPWATCH_LAP_EN to add the L-key lap freeze of the displayed digits.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int RX_TIMEOUT = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kbClk,
   input  logic       kbData,
   output logic [3:0] d1,
   output logic [3:0] d2,
   output logic [3:0] d3,
   output logic [3:0] d4,
   output logic       de
);

   localparam int PW = $clog2(TICK_DIV);

   logic [7:0]    code;
   logic          code_valid;
   logic          brk_q;
   logic          tog, clr;
   logic          tick;
   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   bcd_time_t     live_q, live_d;
   logic          de_q, de_d;
`ifdef STOPWATCH_LAP_EN
   logic          lapk;
   logic          lap_q, lap_d;
   bcd_time_t     disp_q, disp_d;
`endif

   ps2_rx #(
      .RX_TIMEOUT(RX_TIMEOUT)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .kb_clk    (kbClk),
      .kb_data   (kbData),
      .code      (code),
      .code_valid(code_valid)
   );

   // Turn make codes into commands; the byte after F0 is swallowed.
   always_comb begin
      tog = 1'b0;
      clr = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lapk = 1'b0;
`endif
      if (code_valid && !brk_q) begin
         unique case (1'b1)
            (code == KEY_SPACE): tog = 1'b1;
            (code == KEY_R):     clr = 1'b1;
`ifdef STOPWATCH_LAP_EN
            (code == KEY_L):     lapk = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   // Next state, prescaler, live time and dot; pause beats a same-cycle tick.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      live_d  = live_q;
      tick    = (state_q == RUN) && (pre_q == PW'(TICK_DIV - 1));
      unique case (state_q)
         IDLE: begin
            if (tog) begin
               state_d = RUN;
               pre_d   = '0;
            end
         end
         RUN: begin
            if (tog) begin
               state_d = PAUSE;
            end else if (tick) begin
               pre_d  = '0;
               live_d = bcd_inc(live_q);
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         PAUSE: begin
            if (tog) begin
               state_d = RUN;
            end else if (clr) begin
               state_d = IDLE;
               pre_d   = '0;
               live_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      de_d = (state_q == RUN) ? (pre_q < PW'(TICK_DIV / 2)) : 1'b1;
`ifdef STOPWATCH_LAP_EN
      lap_d = lap_q;
      if (tog || clr)
         lap_d = 1'b0;
      else if (lapk && state_q == RUN)
         lap_d = ~lap_q;
      disp_d = lap_d ? disp_q : live_d;
      if (lap_d)
         de_d = 1'b1;
`endif
   end

   // State, prescaler, time and break-prefix registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pre_q   <= '0;
         live_q  <= '0;
         de_q    <= 1'b1;
         brk_q   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_q   <= 1'b0;
         disp_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         live_q  <= live_d;
         de_q    <= de_d;
         if (code_valid) begin
            if (brk_q)
               brk_q <= 1'b0;
            else if (code == BRK)
               brk_q <= 1'b1;
         end
`ifdef STOPWATCH_LAP_EN
         lap_q  <= lap_d;
         disp_q <= disp_d;
`endif
      end
   end

`ifdef STOPWATCH_LAP_EN
   assign d1 = disp_q.d1;
   assign d2 = disp_q.d2;
   assign d3 = disp_q.d3;
   assign d4 = disp_q.d4;
`else
   assign d1 = live_q.d1;
   assign d2 = live_q.d2;
   assign d3 = live_q.d3;
   assign d4 = live_q.d4;
`endif
   assign de = de_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=10, RX_TIMEOUT=200.
// Expected digit changes are queued by a bench time model and popped on DUT change.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int TD = 10;
   localparam int RT = 200;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   localparam int C_NONE = 0;
   localparam int C_TOG  = 1;
   localparam int C_CLR  = 2;
   localparam int C_LAP  = 3;
`ifdef STOPWATCH_LAP_EN
   localparam int C_LK = C_LAP;
`else
   localparam int C_LK = C_NONE;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       kbClk = 1'b1;
   logic       kbData = 1'b1;
   logic [3:0] d1, d2, d3, d4;
   logic       de;

   int n_chk  = 0;
   int n_pass = 0;

   int          mst, mt, mpre, mcmd;
   bit          mlap;
   logic [15:0] mfrz;
   logic [15:0] sb_q[$];
   logic [15:0] last = '0;

   stopwatch_ctrl #(
      .TICK_DIV  (TD),
      .RX_TIMEOUT(RT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .kbClk (kbClk),
      .kbData(kbData),
      .d1    (d1),
      .d2    (d2),
      .d3    (d3),
      .d4    (d4),
      .de    (de)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [15:0] dig();
      return {d4, d3, d2, d1};
   endfunction

   function automatic logic [15:0] to_bcd(input int s);
      int m, x;
      m = (s % 3600) / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   // One clock edge of the bench time model.
   task automatic step();
      logic [15:0] od, nd;
      bit tk;
      @(posedge clk);
      od = mlap ? mfrz : to_bcd(mt);
      tk = (mst == M_RUN) && (mpre == TD - 1);
      if (mcmd == C_TOG) begin
         if (mst == M_IDLE) begin
            mst  = M_RUN;
            mpre = 0;
         end else if (mst == M_RUN) begin
            mst  = M_PAUSE;
            mlap = 1'b0;
         end else begin
            mst = M_RUN;
         end
      end else begin
         if (mcmd == C_CLR) begin
            if (mst == M_PAUSE) begin
               mst  = M_IDLE;
               mt   = 0;
               mpre = 0;
            end
            mlap = 1'b0;
         end
         if (mcmd == C_LAP && mst == M_RUN) begin
            mlap = !mlap;
            mfrz = od;
         end
         if (mst == M_RUN) begin
            if (tk) begin
               mpre = 0;
               mt   = (mt + 1) % 3600;
            end else begin
               mpre++;
            end
         end
      end
      mcmd = C_NONE;
      nd = mlap ? mfrz : to_bcd(mt);
      if (nd != od)
         sb_q.push_back(nd);
   endtask

   // Stop-bit fall lands 84 edges in; its command takes effect on edge 88.
   task automatic send_frame(input logic [7:0] code, input logic bad_par,
                             input logic bad_stop, input int nbits,
                             input int cmd);
      logic [10:0] f;
      f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         step();
         #1 kbData = f[i];
         repeat (3) step();
         #1 kbClk = 1'b0;
         if (i < nbits - 1) begin
            repeat (4) step();
            #1 kbClk = 1'b1;
         end
      end
      repeat (3) step();
      mcmd = cmd;
      step();
      #1 kbClk = 1'b1;
      kbData = 1'b1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      kbClk  = 1'b1;
      kbData = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dig", dig(), 16'h0000);
      check("rst_de", de, 1);
      mst  = M_IDLE;
      mt   = 0;
      mpre = 0;
      mcmd = C_NONE;
      mlap = 1'b0;
      mfrz = '0;
      sb_q.delete();
      last = '0;
      rst  = 1'b0;
   endtask

   task automatic quiet(input string tag);
      int lows;
      lows = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         @(negedge clk);
         if (!de) lows++;
      end
      check(tag, lows, 0);
   endtask

   // Scoreboard: every change of the digit outputs must match the queue head.
   always @(negedge clk) begin
      logic [15:0] cur, e;
      if (!rst) begin
         cur = dig();
         if (cur != last) begin
            if (sb_q.size() == 0) begin
               check("sb_unexp", cur, last);
            end else begin
               e = sb_q.pop_front();
               check("sb", cur, e);
            end
            last = cur;
         end
      end
   end

   initial begin
      int g, lows, tp;
      do_reset();

      send_frame(KEY_SPACE, 1'b1, 1'b0, 11, C_NONE);
      quiet("bad_par");
      send_frame(KEY_SPACE, 1'b0, 1'b1, 11, C_NONE);
      quiet("bad_stop");
      send_frame(BRK, 1'b0, 1'b0, 11, C_NONE);
      send_frame(KEY_SPACE, 1'b0, 1'b0, 11, C_NONE);
      quiet("brk_space");
      send_frame(EXT, 1'b0, 1'b0, 11, C_NONE);
      send_frame(KEY_R, 1'b0, 1'b0, 11, C_NONE);
      quiet("r_idle");
      send_frame(KEY_SPACE, 1'b0, 1'b0, 5, C_NONE);
      repeat (210) step();

      // RUN starts at relative edge 4; first increment at edge 14.
      send_frame(KEY_SPACE, 1'b0, 1'b0, 11, C_TOG);
      for (int n = 5; n <= 24; n++) begin
         step();
         @(negedge clk);
         if (n >= 10)
            check($sformatf("de_n%0d", n), de, ((n - 5) % 10) < 5);
         if (n == 13) check("d1_pre", d1, 0);
         if (n == 14) check("d1_first", d1, 1);
      end

      send_frame(KEY_R, 1'b0, 1'b0, 11, C_CLR);
      step();
      @(negedge clk);
      check("r_run", dig(), to_bcd(mt));

      send_frame(KEY_L, 1'b0, 1'b0, 11, C_LK);
      lows = 0;
      for (int i = 0; i < 35; i++) begin
         step();
         @(negedge clk);
         if (!de) lows++;
      end
`ifdef STOPWATCH_LAP_EN
      check("lap_de", lows, 0);
      check("lap_hold", dig(), mfrz);
`else
      check("nolap_de", lows > 0, 1);
`endif
      send_frame(KEY_L, 1'b0, 1'b0, 11, C_LK);
      step();
      @(negedge clk);
      check("lap_rel", dig(), to_bcd(mt));

      // Pause lands on a tick cycle when the frame starts with prescaler 2.
      g = 0;
      while ((mst != M_RUN || mpre != 2) && g < 50) begin
         step();
         g++;
      end
      check("align", g < 50, 1);
      send_frame(KEY_SPACE, 1'b0, 1'b0, 11, C_TOG);
      tp = mt;
      repeat (15) step();
      @(negedge clk);
      check("ptick_dig", dig(), to_bcd(tp));
      check("ptick_de", de, 1);
      send_frame(KEY_SPACE, 1'b0, 1'b0, 11, C_TOG);
      @(negedge clk);
      check("resume0", dig(), to_bcd(tp));
      step();
      @(negedge clk);
      check("resume1", dig(), to_bcd(tp + 1));

      send_frame(KEY_SPACE, 1'b0, 1'b0, 11, C_TOG);
      repeat (30) step();
      @(negedge clk);
      check("pause_de", de, 1);
      check("pause_dig", dig(), to_bcd(mt));
      send_frame(KEY_R, 1'b0, 1'b0, 11, C_CLR);
      @(negedge clk);
      check("clr_dig", dig(), 16'h0000);
      check("clr_de", de, 1);

      send_frame(KEY_SPACE, 1'b0, 1'b0, 11, C_TOG);
      g = 0;
      while (mt != 3599 && g < 40000) begin
         step();
         g++;
      end
      @(negedge clk);
      check("at_5959", dig(), 16'h5959);
      g = 0;
      while (mt != 0 && g < 20) begin
         step();
         g++;
      end
      @(negedge clk);
      check("wrap_0000", dig(), 16'h0000);
      g = 0;
      while (mt != 1 && g < 20) begin
         step();
         g++;
      end
      @(negedge clk);
      check("after_wrap", dig(), 16'h0001);

      send_frame(KEY_SPACE, 1'b0, 1'b0, 6, C_NONE);
      check("sb_pre_rst", sb_q.size(), 0);
      do_reset();
      send_frame(KEY_SPACE, 1'b0, 1'b0, 11, C_TOG);
      repeat (25) step();
      @(negedge clk);
      check("post_rst", dig(), 16'h0002);

      repeat (3) step();
      @(negedge clk);
      check("sb_drain", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
